// File: rtl/priority_encoder_stream.sv
// Registered priority encoder with valid/ready streams on both sides.
// Run-time MSB-first, LSB-first or round-robin priority; all-zero inputs are flagged.
module priority_encoder_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   Clock_In,
  input  logic                   Reset_n_In,
  input  logic                   Enable_In,
  input  logic [1:0]             Mode_In,
  input  logic [DATA_WIDTH-1:0]  Data_In,
  input  logic                   Data_Valid_In,
  output logic                   Data_Ready_Out,
  output logic [INDEX_WIDTH-1:0] Encoded_Value_Out,
  output logic                   No_Match_Out,
  output logic                   Encoded_Valid_Out,
  input  logic                   Encoded_Ready_In
);

  typedef enum logic [1:0] {
    MODE_MSB     = 2'b00,
    MODE_LSB     = 2'b01,
    MODE_RR      = 2'b10,
    MODE_MSB_ALT = 2'b11
  } mode_e;

  mode_e                   mode;
  logic                    accept;
  logic [INDEX_WIDTH-1:0]  rr_ptr;
  logic [DATA_WIDTH-1:0]   rr_mask;
  logic [DATA_WIDTH-1:0]   rr_masked;
  logic [INDEX_WIDTH-1:0]  rr_winner;
  logic [INDEX_WIDTH-1:0]  winner;
  logic [INDEX_WIDTH-1:0]  rr_next;
  logic                    no_match;

  function automatic logic [INDEX_WIDTH-1:0] lowest_set(input logic [DATA_WIDTH-1:0] vec);
    lowest_set = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = INDEX_WIDTH'(i);
    end
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] highest_set(input logic [DATA_WIDTH-1:0] vec);
    highest_set = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (vec[i]) highest_set = INDEX_WIDTH'(i);
    end
  endfunction

  assign mode           = mode_e'(Mode_In);
  assign Data_Ready_Out = Enable_In && (!Encoded_Valid_Out || Encoded_Ready_In);
  assign accept         = Data_Valid_In && Data_Ready_Out;
  assign no_match       = ~|Data_In;

  // Round-robin: lowest set bit at or above the pointer, else wrap to the lowest set bit overall.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    rr_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rr_mask[i] = (INDEX_WIDTH'(i) >= rr_ptr);
    end
    rr_masked = Data_In & rr_mask;
    rr_winner = (|rr_masked) ? lowest_set(rr_masked) : lowest_set(Data_In);
  end

  always_comb begin
    winner = '0;
    case (mode)
      MODE_LSB: winner = lowest_set(Data_In);
      MODE_RR:  winner = rr_winner;
      default:  winner = highest_set(Data_In);
    endcase
    rr_next = (winner == INDEX_WIDTH'(DATA_WIDTH - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
      Encoded_Value_Out <= '0;
      No_Match_Out      <= 1'b0;
      Encoded_Valid_Out <= 1'b0;
      rr_ptr            <= '0;
    end else begin
      if (accept) begin
        Encoded_Value_Out <= no_match ? '0 : winner;
        No_Match_Out      <= no_match;
        Encoded_Valid_Out <= 1'b1;
        if (mode == MODE_RR && !no_match) rr_ptr <= rr_next;
      end else if (Encoded_Valid_Out && Encoded_Ready_In) begin
        Encoded_Valid_Out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Self-checking bench: directed scenarios on 32- and 5-bit instances plus a randomized
// stream on the 32-bit instance checked against a cycle-level reference model.
module tb_priority_encoder_stream;

  logic        clk;
  logic        rst_n;

  logic        en, dv, dr, nm, eval, erdy;
  logic [1:0]  mode;
  logic [31:0] din;
  logic [4:0]  ev;

  logic        en5, dv5, dr5, nm5, eval5, erdy5;
  logic [1:0]  mode5;
  logic [4:0]  din5;
  logic [2:0]  ev5;

  int tests_run    = 0;
  int tests_failed = 0;

  priority_encoder_stream #(.DATA_WIDTH(32), .INDEX_WIDTH(5)) dut32 (
    .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Mode_In(mode),
    .Data_In(din), .Data_Valid_In(dv), .Data_Ready_Out(dr),
    .Encoded_Value_Out(ev), .No_Match_Out(nm), .Encoded_Valid_Out(eval),
    .Encoded_Ready_In(erdy)
  );

  priority_encoder_stream #(.DATA_WIDTH(5), .INDEX_WIDTH(3)) dut5 (
    .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en5), .Mode_In(mode5),
    .Data_In(din5), .Data_Valid_In(dv5), .Data_Ready_Out(dr5),
    .Encoded_Value_Out(ev5), .No_Match_Out(nm5), .Encoded_Valid_Out(eval5),
    .Encoded_Ready_In(erdy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: returns the winning index, or -1 for an all-zero vector.
  function automatic int ref_encode(input logic [31:0] d, input int m, input int ptr);
    int idx;
    if (d == 32'h0) return -1;
    if (m == 1) begin
      for (int i = 0; i < 32; i++) if (d[i]) return i;
    end else if (m == 2) begin
      for (int k = 0; k < 32; k++) begin
        idx = (ptr + k) % 32;
        if (d[idx]) return idx;
      end
    end else begin
      for (int i = 31; i >= 0; i--) if (d[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; dv = 1'b0; mode = 2'b00; din = '0; erdy = 1'b1;
    en5 = 1'b1; dv5 = 1'b0; mode5 = 2'b00; din5 = '0; erdy5 = 1'b1;
    #3;
    tests_run++;
    if ({eval, nm, ev} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs32: got v/nm/idx=%b/%b/%0d expected 0/0/0", eval, nm, ev);
    end
    tests_run++;
    if (dr !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready32: got %b expected 1", dr);
    end
    tests_run++;
    if ({eval5, nm5, ev5, dr5} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_state5: got v/nm/idx/rdy=%b/%b/%0d/%b expected 0/0/0/1", eval5, nm5, ev5, dr5);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_msb_lsb();
    mode = 2'b00; din = 32'h0000_8001; dv = 1'b1; erdy = 1'b1;
    tick();
    mode = 2'b01;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b0, 5'd15}) begin
      tests_failed++;
      $display("FAIL msb_8001: got v/nm/idx=%b/%b/%0d expected 1/0/15", eval, nm, ev);
    end
    tick();
    din = 32'h0;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL lsb_8001: got v/nm/idx=%b/%b/%0d expected 1/0/0", eval, nm, ev);
    end
    tick();
    dv = 1'b0; mode = 2'b11; din = 32'h0000_0300;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b1, 5'd0}) begin
      tests_failed++;
      $display("FAIL zero_vector: got v/nm/idx=%b/%b/%0d expected 1/1/0", eval, nm, ev);
    end
    tick();
    tests_run++;
    if (eval !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_after_zero: got valid=%b expected 0", eval);
    end
    // Mode 11 behaves as MSB-first.
    dv = 1'b1;
    tick();
    dv = 1'b0;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b0, 5'd9}) begin
      tests_failed++;
      $display("FAIL mode11_msb: got v/nm/idx=%b/%b/%0d expected 1/0/9", eval, nm, ev);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 4, 31, 0};
    mode = 2'b10; din = 32'h8000_0011; dv = 1'b1; erdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({eval, nm, ev} !== {1'b1, 1'b0, 5'(exp_seq[k])}) begin
        tests_failed++;
        $display("FAIL rr_seq[%0d]: got v/nm/idx=%b/%b/%0d expected 1/0/%0d", k, eval, nm, ev, exp_seq[k]);
      end
    end
    // Pointer is now 1: 0x3 must pick bit 1.
    din = 32'h3;
    tick();
    tests_run++;
    if (ev !== 5'd1) begin
      tests_failed++;
      $display("FAIL rr_ptr_after_seq: got idx=%0d expected 1", ev);
    end
    // All-zero vector leaves the pointer at 2, so 0x3 wraps to bit 0.
    din = 32'h0;
    tick();
    din = 32'h3;
    tick();
    tests_run++;
    if ({nm, ev} !== {1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL rr_zero_keeps_ptr: got nm/idx=%b/%0d expected 0/0", nm, ev);
    end
    // MSB accept leaves the pointer at 1.
    mode = 2'b00; din = 32'h3;
    tick();
    mode = 2'b10;
    tick();
    tests_run++;
    if (ev !== 5'd1) begin
      tests_failed++;
      $display("FAIL rr_msb_keeps_ptr: got idx=%0d expected 1", ev);
    end
    dv = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    mode = 2'b00; erdy = 1'b0; din = 32'h4; dv = 1'b1;
    tick();
    din = 32'h8;
    tests_run++;
    if ({eval, nm, ev, dr} !== {1'b1, 1'b0, 5'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_first: got v/nm/idx/rdy=%b/%b/%0d/%b expected 1/0/2/0", eval, nm, ev, dr);
    end
    tick();
    tests_run++;
    if ({eval, nm, ev, dr} !== {1'b1, 1'b0, 5'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_hold: got v/nm/idx/rdy=%b/%b/%0d/%b expected 1/0/2/0", eval, nm, ev, dr);
    end
    erdy = 1'b1;
    #1;
    tests_run++;
    if (dr !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_comb: got %b expected 1", dr);
    end
    tick();
    dv = 1'b0;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b0, 5'd3}) begin
      tests_failed++;
      $display("FAIL bp_second: got v/nm/idx=%b/%b/%0d expected 1/0/3", eval, nm, ev);
    end
    tick();
    tests_run++;
    if (eval !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got valid=%b expected 0", eval);
    end
  endtask

  task automatic test_enable();
    mode = 2'b00; erdy = 1'b0; en = 1'b1; din = 32'h10; dv = 1'b1;
    tick();
    en = 1'b0; din = 32'h20;
    #1;
    tests_run++;
    if (dr !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_ready_low: got %b expected 0", dr);
    end
    tick();
    erdy = 1'b1;
    tests_run++;
    if ({eval, ev} !== {1'b1, 5'd4}) begin
      tests_failed++;
      $display("FAIL en_pending_hold: got v/idx=%b/%0d expected 1/4", eval, ev);
    end
    #1;
    tests_run++;
    if (dr !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_ready_with_erdy: got %b expected 0", dr);
    end
    tick();
    tests_run++;
    if (eval !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_drain: got valid=%b expected 0", eval);
    end
    tick();
    tests_run++;
    if (eval !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_no_accept: got valid=%b expected 0", eval);
    end
    en = 1'b1;
    tick();
    dv = 1'b0;
    tests_run++;
    if ({eval, nm, ev} !== {1'b1, 1'b0, 5'd5}) begin
      tests_failed++;
      $display("FAIL en_resume: got v/nm/idx=%b/%b/%0d expected 1/0/5", eval, nm, ev);
    end
    tick();
  endtask

  task automatic test_width5();
    int exp_seq[3] = '{0, 4, 0};
    mode5 = 2'b10; din5 = 5'b10001; dv5 = 1'b1; erdy5 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin
        dv5 = 1'b0; erdy5 = 1'b0;
      end
      tests_run++;
      if ({eval5, nm5, ev5} !== {1'b1, 1'b0, 3'(exp_seq[k])}) begin
        tests_failed++;
        $display("FAIL w5_rr[%0d]: got v/nm/idx=%b/%b/%0d expected 1/0/%0d", k, eval5, nm5, ev5, exp_seq[k]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({eval5, nm5, ev5} !== 5'b0) begin
      tests_failed++;
      $display("FAIL w5_async_reset: got v/nm/idx=%b/%b/%0d expected 0/0/0", eval5, nm5, ev5);
    end
    tick();
    rst_n = 1'b1;
    erdy5 = 1'b1; dv5 = 1'b1;
    tick();
    dv5 = 1'b0;
    tests_run++;
    if ({eval5, nm5, ev5} !== {1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL w5_after_reset: got v/nm/idx=%b/%b/%0d expected 1/0/0", eval5, nm5, ev5);
    end
    // LSB and MSB on a non-power-of-two width.
    mode5 = 2'b00; din5 = 5'b10110; dv5 = 1'b1;
    tick();
    mode5 = 2'b01;
    tests_run++;
    if (ev5 !== 3'd4) begin
      tests_failed++;
      $display("FAIL w5_msb: got idx=%0d expected 4", ev5);
    end
    tick();
    dv5 = 1'b0;
    tests_run++;
    if (ev5 !== 3'd1) begin
      tests_failed++;
      $display("FAIL w5_lsb: got idx=%0d expected 1", ev5);
    end
    tick();
  endtask

  task automatic test_random_stream();
    bit m_valid = 1'b0;
    bit m_nm    = 1'b0;
    int m_value = 0;
    int m_ptr   = 0;
    bit acc;
    bit exp_rdy;
    int r;
    int cur_mode;
    logic [31:0] cur_din;
    rst_n = 1'b0; dv = 1'b0; en = 1'b1; erdy = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 500; n++) begin
      en   = ($urandom_range(0, 9) != 0);
      dv   = ($urandom_range(0, 9) < 7);
      erdy = ($urandom_range(0, 9) < 7);
      mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       din = 32'h0;
        1:       din = 32'h1 << $urandom_range(0, 31);
        2:       din = $urandom & $urandom & $urandom;
        default: din = $urandom;
      endcase
      #1;
      exp_rdy = en && (!m_valid || erdy);
      tests_run++;
      if (dr !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rnd_ready[%0d]: got %b expected %b", n, dr, exp_rdy);
      end
      acc      = dv && exp_rdy;
      cur_mode = int'(mode);
      cur_din  = din;
      tick();
      if (acc) begin
        r       = ref_encode(cur_din, cur_mode, m_ptr);
        m_valid = 1'b1;
        m_nm    = (r < 0);
        m_value = (r < 0) ? 0 : r;
        if (cur_mode == 2 && r >= 0) m_ptr = (r + 1) % 32;
      end else if (m_valid && erdy) begin
        m_valid = 1'b0;
      end
      tests_run++;
      if (eval !== m_valid || (m_valid && (nm !== m_nm || ev !== 5'(m_value)))) begin
        tests_failed++;
        $display("FAIL rnd_out[%0d]: got v/nm/idx=%b/%b/%0d expected %b/%b/%0d",
                 n, eval, nm, ev, m_valid, m_nm, m_value);
      end
    end
    dv = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_width5();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_encoder_stream.md
Name: priority_encoder_stream

Overview:
Parametrised, registered priority encoder with a valid/ready stream interface on input and output. It generalises the fixed 32:5 combinational encoders to any width. It adds run-time selection of MSB-first, LSB-first or round-robin priority, and reports all-zero vectors explicitly. It sits between request-collection logic and downstream index consumers such as arbiters, interrupt dispatch and mux selects.

Parameters:
DATA_WIDTH, 32, number of request bits; legal 2..256.
INDEX_WIDTH, 5, width of encoded index; must equal ceil(log2(DATA_WIDTH)).

Ports:
Clock_In  input  1  rising-edge clock.
Reset_n_In  input  1  asynchronous, active-low reset.
Enable_In  input  1  block enable; low stalls input acceptance.
Mode_In  input  2  00 high-priority (MSB wins), 01 low-priority (LSB wins), 10 round-robin, 11 treated as 00.
Data_In  input  DATA_WIDTH  request vector.
Data_Valid_In  input  1  Data_In/Mode_In valid.
Data_Ready_Out  output  1  block can accept input this cycle.
Encoded_Value_Out  output  INDEX_WIDTH  winning bit index.
No_Match_Out  output  1  accepted vector was all zeros.
Encoded_Valid_Out  output  1  output result valid.
Encoded_Ready_In  input  1  downstream accepts result.

Behaviour:
- Reset (async assert, sync release): Encoded_Value_Out=0, No_Match_Out=0, Encoded_Valid_Out=0, round-robin pointer RR_Ptr=0. Data_Ready_Out follows its combinational equation, so it is 1 during reset if Enable_In=1.
- Data_Ready_Out = Enable_In && (!Encoded_Valid_Out || Encoded_Ready_In). It is combinational and has no dependence on Data_Valid_In.
- Accept = Data_Valid_In && Data_Ready_Out. On accept, the result registers load on the next rising edge. Latency is 1 cycle, and full throughput is one result per cycle when Encoded_Ready_In is held high.
- Output register: Encoded_Valid_Out sets on accept. It clears on an Encoded_Ready_In handshake with no simultaneous accept. When accept and output handshake occur in the same cycle, the new result replaces the old one and valid stays 1.
- While Encoded_Valid_Out=1 and Encoded_Ready_In=0, all outputs hold stable.
- Enable_In=0: no accept. A pending output stays valid and can still drain. RR_Ptr holds.
- Mode 00: index of the highest set bit. Mode 01: index of the lowest set bit.
- Mode 10: first set bit at index >= RR_Ptr, searching upward and wrapping from DATA_WIDTH-1 to 0.
  - On accept of a non-zero vector in mode 10, RR_Ptr <= winner+1, wrapping to 0 when winner = DATA_WIDTH-1.
  - RR_Ptr is unchanged by accepts in modes 00, 01 and 11, and by all-zero vectors.
- All-zero accepted vector: Encoded_Value_Out=0, No_Match_Out=1, Encoded_Valid_Out=1. It is still a result and must be handshaken.
- Non-zero vector: No_Match_Out=0.
- Mode_In is sampled only on accept. A mode change between accepts takes effect on the next accept with no flush.
- Encoded_Value_Out is zero-extended when DATA_WIDTH is not a power of 2. Indices >= DATA_WIDTH are never produced.
- Reset asserted mid-stream: the pending output is discarded immediately and RR_Ptr returns to 0.
- No X or Z is driven on any output at any time.

Test Plan:
1. Mode 00, DATA_WIDTH=32, Data_In=0x0000_8001, ready held 1 -> one cycle later Encoded_Value_Out=15, No_Match_Out=0, Encoded_Valid_Out=1.
2. Mode 01, Data_In=0x0000_8001 -> Encoded_Value_Out=0. Then Data_In=0 -> Encoded_Value_Out=0, No_Match_Out=1, valid=1.
3. Mode 10 from reset, Data_In=0x8000_0011 presented on four consecutive accepts -> outputs 0, 4, 31, 0. RR_Ptr after each: 1, 5, 0, 1.
4. Backpressure: Encoded_Ready_In=0 with two inputs offered (0x4 then 0x8, mode 00) -> first result 2 holds with Data_Ready_Out=0. Raise ready -> result 2 handshakes and 0x8 is accepted the same cycle, then 3 appears.
5. Enable_In=0 with Data_Valid_In=1 -> Data_Ready_Out=0, no new result, pending result drains when Encoded_Ready_In=1. Reasserting Enable_In resumes acceptance.
6. DATA_WIDTH=5, INDEX_WIDTH=3, mode 10, Data_In=5'b10001: accepts give 0, 4, 0. Then assert Reset_n_In low mid-handshake -> all outputs 0 asynchronously. Next accept of 5'b10001 gives 0.
